oled_refresh: RTL

Frame-refresh sequencer for the SSD1351-class OLED on the 8-bit parallel bus. Once the power-on init sequencer signals completion, each accepted `start` makes this block send a full-frame window setup: column address, row address, then write-RAM. It then streams every 16-bit RGB565 pixel from a framebuffer read port as two bus bytes. The block sits between the init sequencer and the video framebuffer and owns the OLED bus after init.

---
 rtl/oled_pkg.sv | 24 ++
 rtl/oled_refresh_if.sv | 13 +
 rtl/oled_byte_tx.sv | 27 ++
 rtl/oled_refresh.sv | 87 ++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// oled_pkg: shared OLED opcodes, refresh FSM states, default geometry and command-byte lookup
//   OLED_CMD_*   : SSD1351 opcodes, also used by the init sequencer
//   state_t      : refresh sequencer states
//   cmd_byte()   : {dc, byte} of window-setup command byte i for a w x h frame
package oled_pkg;
   localparam logic [7:0] OLED_CMD_SET_COL   = 8'h15;
   localparam logic [7:0] OLED_CMD_SET_ROW   = 8'h75;
   localparam logic [7:0] OLED_CMD_WRITE_RAM = 8'h5C;
   localparam int OLED_WIDTH      = 128;
   localparam int OLED_HEIGHT     = 128;
   localparam int OLED_ADDR_WIDTH = 14;
   typedef enum logic [1:0] {IDLE, CMD, PIX_HI, PIX_LO} state_t;
   function automatic logic [8:0] cmd_byte(input logic [2:0] i, input int w, input int h);
      case (i)
         3'd0: return {1'b0, OLED_CMD_SET_COL};
         3'd1: return {1'b1, 8'h00};
         3'd2: return {1'b1, 8'(w - 1)};
         3'd3: return {1'b0, OLED_CMD_SET_ROW};
         3'd4: return {1'b1, 8'h00};
         3'd5: return {1'b1, 8'(h - 1)};
         default: return {1'b0, OLED_CMD_WRITE_RAM};
      endcase
   endfunction
endpackage

// File: rtl/oled_refresh_if.sv
// oled_refresh_if: OLED 8-bit bus plus framebuffer read port
//   master: oled_cs/oled_e/oled_dc/oled_dout/fb_addr out, fb_data in (refresh sequencer side)
//   slave : the reverse (panel + framebuffer side)
interface oled_refresh_if import oled_pkg::*; #(parameter int ADDR_WIDTH = OLED_ADDR_WIDTH);
   logic                  oled_cs;
   logic                  oled_e;
   logic                  oled_dc;
   logic [7:0]            oled_dout;
   logic [ADDR_WIDTH-1:0] fb_addr;
   logic [15:0]           fb_data;
   modport master(output oled_cs, oled_e, oled_dc, oled_dout, fb_addr, input fb_data);
   modport slave(input oled_cs, oled_e, oled_dc, oled_dout, fb_addr, output fb_data);
endinterface

// File: rtl/oled_byte_tx.sv
// oled_byte_tx: two-cycle bus byte slot (phase A strobe high, phase B strobe low, data held)
//   load/word : start a slot with word = {dc, byte}
//   e/dc/dout : registered bus strobe, data/command flag and byte
//   slot_end  : high during phase B, the cycle in which the next slot may be loaded
module oled_byte_tx (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [8:0] word,
   output logic       e,
   output logic       dc,
   output logic [7:0] dout,
   output logic       slot_end
);
   always_ff @(posedge clk) begin
      if (rst) begin
         e        <= 1'b0;
         slot_end <= 1'b0;
         dc       <= 1'b0;
         dout     <= 8'h00;
      end else begin
         e        <= load;
         slot_end <= e & ~load;
         if (load) {dc, dout} <= word;
      end
   end
endmodule

// File: rtl/oled_refresh.sv
// oled_refresh: frame-refresh sequencer, window setup commands then RGB565 pixel stream
//   clk/rst          : clock, synchronous active-high reset
//   ready/start      : init done level, frame request
//   busy/frame_done  : frame in progress, one-cycle end-of-frame pulse
//   bus              : OLED bus and framebuffer read port (master side)
module oled_refresh import oled_pkg::*; #(
   parameter int WIDTH      = OLED_WIDTH,
   parameter int HEIGHT     = OLED_HEIGHT,
   parameter int ADDR_WIDTH = OLED_ADDR_WIDTH
) (
   input  logic clk,
   input  logic rst,
   input  logic ready,
   input  logic start,
   output logic busy,
   output logic frame_done,
   oled_refresh_if.master bus
);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WIDTH * HEIGHT - 1);
   state_t                st;
   logic [2:0]            idx;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [15:0]           px;
   logic                  accept, load, slot_end, tx_e, tx_dc;
   logic [7:0]            tx_dout;
   logic [8:0]            nxt;
   always_comb begin
      accept = st == IDLE && start && ready;
      load   = accept || (slot_end && !(st == PIX_LO && cnt == LAST));
      nxt    = accept ? cmd_byte(3'd0, WIDTH, HEIGHT) :
               st == CMD && idx != 3'd6 ? cmd_byte(idx + 3'd1, WIDTH, HEIGHT) :
               st == PIX_HI ? {1'b1, px[7:0]} : {1'b1, 8'h00};
   end
   oled_byte_tx tx (
      .clk(clk), .rst(rst), .load(load), .word(nxt),
      .e(tx_e), .dc(tx_dc), .dout(tx_dout), .slot_end(slot_end)
   );
   // The high byte arrives from the RAM during its own phase A, so it is forwarded
   // straight to the bus and then held from the pixel register in phase B.
   assign bus.oled_e    = tx_e;
   assign bus.oled_dc   = tx_dc;
   assign bus.oled_dout = st == PIX_HI ? (tx_e ? bus.fb_data[15:8] : px[15:8]) : tx_dout;
   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= IDLE;
         idx         <= 3'd0;
         cnt         <= '0;
         px          <= 16'h0000;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         bus.oled_cs <= 1'b1;
         bus.fb_addr <= '0;
      end else begin
         frame_done <= 1'b0;
         if (st == PIX_HI && tx_e) px <= bus.fb_data;
         // Next address goes out in PIX_LO phase B (or last CMD cycle) for a one-cycle RAM.
         if (st == CMD && idx == 3'd6 && tx_e) bus.fb_addr <= '0;
         if (st == PIX_LO && tx_e && cnt != LAST) bus.fb_addr <= cnt + 1'b1;
         case (st)
            IDLE: if (accept) begin
               st          <= CMD;
               idx         <= 3'd0;
               cnt         <= '0;
               busy        <= 1'b1;
               bus.oled_cs <= 1'b0;
            end
            CMD: if (slot_end) begin
               if (idx == 3'd6) st <= PIX_HI;
               else idx <= idx + 3'd1;
            end
            PIX_HI: if (slot_end) st <= PIX_LO;
            PIX_LO: if (slot_end) begin
               if (cnt == LAST) begin
                  st          <= IDLE;
                  busy        <= 1'b0;
                  bus.oled_cs <= 1'b1;
                  frame_done  <= 1'b1;
               end else begin
                  st  <= PIX_HI;
                  cnt <= cnt + 1'b1;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule
